// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Latches the granted operands, captures result/flags, and commits NZCV on the response handshake.
module alu_rr_arbiter #(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [N-1:0]     req0_a,
   input  logic [N-1:0]     req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [N-1:0]     req1_a,
   input  logic [N-1:0]     req1_b,
   input  logic [1:0]       req1_op,
   output logic [N-1:0]     alu_a,
   output logic [N-1:0]     alu_b,
   output logic [1:0]       alu_ctrl,
   input  logic [N-1:0]     alu_out,
   input  logic [3:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [N-1:0]     rsp_result,
   output logic [3:0]       rsp_flags,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state, state_next;
   logic           last_grant;
   logic           cur_id;
   logic           grant0, grant1;
   logic [N-1:0]   op_a, op_b;
   logic [1:0]     op_ctrl;

   assign alu_a    = op_a;
   assign alu_b    = op_b;
   assign alu_ctrl = op_ctrl;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (grant0 || grant1) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Contention goes to whichever requester was not served last; ready is masked
   // during reset so no handshake is ever signalled in a cycle that reset discards.
   always_comb begin
      grant0     = req0_valid && (!req1_valid || last_grant);
      grant1     = req1_valid && (!req0_valid || !last_grant);
      req0_ready = (state == IDLE) && !rst && grant0;
      req1_ready = (state == IDLE) && !rst && grant1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a       <= '0;
         op_b       <= '0;
         op_ctrl    <= '0;
         cur_id     <= 1'b0;
         last_grant <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         flags_q    <= '0;
         done_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req0_ready) begin
                  op_a    <= req0_a;
                  op_b    <= req0_b;
                  op_ctrl <= req0_op;
                  cur_id  <= 1'b0;
               end else if (req1_ready) begin
                  op_a    <= req1_a;
                  op_b    <= req1_b;
                  op_ctrl <= req1_op;
                  cur_id  <= 1'b1;
               end
            end
            EXEC: begin
               rsp_result <= alu_out;
               rsp_flags  <= alu_flags;
               rsp_id     <= cur_id;
               rsp_valid  <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  flags_q    <= rsp_flags;
                  done_cnt   <= done_cnt + CNT_W'(1);
                  last_grant <= rsp_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: attaches a behavioural ALU and compares every cycle against a
// transaction-level model of the arbitration, latency and commit rules.
module tb_alu_rr_arbiter;

   localparam int N     = 32;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
   logic [1:0]       req0_op, req1_op;
   logic [N-1:0]     alu_a, alu_b, alu_out;
   logic [1:0]       alu_ctrl;
   logic [3:0]       alu_flags;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [N-1:0]     rsp_result;
   logic [3:0]       rsp_flags, flags_q;
   logic [CNT_W-1:0] done_cnt;

   alu_rr_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .flags_q(flags_q), .done_cnt(done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU arithmetic: returns {N,Z,C,V, result}; C on SUB means "no borrow"
   function automatic logic [N+3:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
      logic [N:0]   s;
      logic [N-1:0] r;
      logic         c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         2'd0: begin s = {1'b0, a} + {1'b0, b};        r = s[N-1:0]; c = s[N]; v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
         2'd1: begin s = {1'b0, a} + {1'b0, ~b} + 1'b1; r = s[N-1:0]; c = s[N]; v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
         2'd2: r = a ^ b;
         default: r = ~a;
      endcase
      return {r[N-1], (r == '0), c, v, r};
   endfunction

   always_comb {alu_flags, alu_out} = alu_ref(alu_a, alu_b, alu_ctrl);

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding op, aged in cycles since acceptance
   typedef struct {
      logic [N-1:0] a, b;
      logic [1:0]   op;
      logic         id;
      int unsigned  age;
   } txn_t;

   txn_t             q[$];
   logic             served_last;
   logic [3:0]       flags_m;
   logic [CNT_W-1:0] done_m;
   logic [N-1:0]     last_a, last_b;
   logic [1:0]       last_op;
   logic             seen0, seen1;

   task automatic model_reset();
      q.delete();
      served_last = 1'b1;
      flags_m = '0;
      done_m = '0;
      last_a = '0; last_b = '0; last_op = '0;
   endtask

   // Called just after inputs are driven; checks, crosses one rising edge, updates the model.
   task automatic cycle();
      logic         e0, e1, pick;
      logic [N+3:0] ref_v;
      txn_t         t;
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (!rst && q.size() == 0) begin
         if (req0_valid && req1_valid) pick = !served_last;
         else                          pick = req1_valid;
         if (req0_valid || req1_valid) begin
            e0 = (pick == 1'b0);
            e1 = (pick == 1'b1);
         end
      end
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      seen0 = req0_ready;
      seen1 = req1_ready;
      check("rsp_valid", rsp_valid, (q.size() > 0 && q[0].age >= 1));
      if (q.size() > 0 && q[0].age >= 1) begin
         ref_v = alu_ref(q[0].a, q[0].b, q[0].op);
         check("rsp_id", rsp_id, q[0].id);
         check("rsp_result", rsp_result, ref_v[N-1:0]);
         check("rsp_flags", rsp_flags, ref_v[N+3:N]);
      end
      check("flags_q", flags_q, flags_m);
      check("done_cnt", done_cnt, done_m);
      check("alu_a", alu_a, last_a);
      check("alu_b", alu_b, last_b);
      check("alu_ctrl", alu_ctrl, last_op);
      @(posedge clk);
      if (rst) model_reset();
      else if (q.size() > 0) begin
         if (q[0].age >= 1 && rsp_ready) begin
            ref_v = alu_ref(q[0].a, q[0].b, q[0].op);
            flags_m = ref_v[N+3:N];
            done_m = done_m + 1'b1;
            served_last = q[0].id;
            void'(q.pop_front());
         end else q[0].age++;
      end else if (e0 || e1) begin
         t.id  = e1;
         t.a   = e1 ? req1_a : req0_a;
         t.b   = e1 ? req1_b : req0_b;
         t.op  = e1 ? req1_op : req0_op;
         t.age = 0;
         q.push_back(t);
         last_a = t.a; last_b = t.b; last_op = t.op;
      end
      #1;
   endtask

   function automatic logic [N-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b0, {(N-1){1'b1}}};
         3:       return {1'b1, {(N-1){1'b0}}};
         default: return N'($urandom);
      endcase
   endfunction

   logic prev_id;
   logic have_prev;

   initial begin
      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Reset state with rst still asserted
      cycle();
      check("t1_rsp_valid", rsp_valid, 1'b0);
      check("t1_done_cnt", done_cnt, 0);
      rst = 1'b0;

      // Single ADD from requester 0
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 2'd0;
      cycle();
      req0_valid = 1'b0;
      cycle();
      check("t2_result", rsp_result, 32'd8);
      check("t2_id", rsp_id, 1'b0);
      check("t2_flags", rsp_flags, 4'b0000);
      cycle();
      check("t2_done", done_cnt, 1);
      check("t2_flags_q", flags_q, 4'b0000);

      // Continuous contention: grants must alternate
      req0_valid = 1'b1; req0_a = 32'd5;    req0_b = 32'd5;    req0_op = 2'd1;
      req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 2'd2;
      have_prev = 1'b0;
      for (int unsigned i = 0; i < 15; i++) begin
         cycle();
         if (seen0 || seen1) begin
            if (have_prev) check("t3_alternate", seen1, !prev_id);
            prev_id = seen1;
            have_prev = 1'b1;
         end
         if (rsp_valid && rsp_id)  check("t3_xor", rsp_result, 32'hFF);
         if (rsp_valid && !rsp_id) check("t3_sub_flags", rsp_flags, 4'b0110);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      while (q.size() != 0) cycle();

      // Backpressure in RESP
      req1_valid = 1'b1; req1_a = 32'h7FFFFFFF; req1_b = 32'd1; req1_op = 2'd0;
      rsp_ready = 1'b0;
      cycle();
      req1_valid = 1'b0; req0_valid = 1'b1;
      for (int unsigned i = 0; i < 6; i++) cycle();
      check("t4_held", rsp_result, 32'h80000000);
      check("t4_flags_held", rsp_flags, 4'b1001);
      rsp_ready = 1'b1;
      cycle();
      check("t4_flags_q", flags_q, 4'b1001);
      req0_valid = 1'b0;
      cycle();

      // Reset in EXEC, then in RESP
      req0_valid = 1'b1; req0_op = 2'd3;
      cycle();
      req0_valid = 1'b0; rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t5_exec_rsp_valid", rsp_valid, 1'b0);
      req1_valid = 1'b1;
      cycle();
      req1_valid = 1'b0; rsp_ready = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0; rsp_ready = 1'b1;
      check("t5_resp_rsp_valid", rsp_valid, 1'b0);
      check("t5_done", done_cnt, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      cycle();
      check("t5_req0_first", seen0, 1'b1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      while (q.size() != 0) cycle();

      // Counter wrap: 16 completions bring done_cnt back to its start value
      begin
         logic [CNT_W-1:0] start_cnt;
         start_cnt = done_cnt;
         req0_valid = 1'b1; req0_op = 2'd0;
         for (int unsigned i = 0; i < 48; i++) cycle();
         req0_valid = 1'b0;
         check("t6_wrap", done_cnt, start_cnt);
      end

      // Randomised traffic
      for (int unsigned i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 49) == 0);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         req0_valid = $urandom_range(0, 1);
         req1_valid = $urandom_range(0, 1);
         req0_a = rand_operand(); req0_b = rand_operand(); req0_op = 2'($urandom);
         req1_a = rand_operand(); req1_b = rand_operand(); req1_op = 2'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
